// File: rtl/aes128_keyexp_ctrl_if.sv
// Key-load, round-key stream and table-read signals of the AES-128 key-expansion sequencer.
// The slave modport is the sequencer; the master modport is the key source / cipher core side.
interface aes128_keyexp_ctrl_if #(
    parameter int KW = 128
);
    logic          key_valid;
    logic          key_ready;
    logic [KW-1:0] key_in;
    logic          abort;
    logic          rk_valid;
    logic          rk_ready;
    logic [KW-1:0] rk_data;
    logic [3:0]    rk_round;
    logic          done;
    logic          tbl_valid;
    logic [3:0]    rd_addr;
    logic [KW-1:0] rd_data;

    modport master (
        output key_valid, key_in, abort, rk_ready, rd_addr,
        input  key_ready, rk_valid, rk_data, rk_round, done, tbl_valid, rd_data
    );

    modport slave (
        input  key_valid, key_in, abort, rk_ready, rd_addr,
        output key_ready, rk_valid, rk_data, rk_round, done, tbl_valid, rd_data
    );
endinterface

// File: rtl/aes128_keyexp_ctrl.sv
// Iterative AES-128 key expansion: one keyschedule round per accepted round key,
// streamed out on valid/ready and kept in an 11-entry table for random (reverse) readback.
module aes128_keyexp_ctrl #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input logic                clk,
    input logic                rst_n,
    aes128_keyexp_ctrl_if.slave bus
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    // FIPS-197 S-box, entry 0 in the top byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] rk_data_q;
    logic [3:0]    rk_round_q;
    logic          tbl_valid_q;
    logic [KW-1:0] tbl [NR+1];

    logic          key_accept;
    logic          rk_fire;
    logic          last_rnd;
    logic [3:0]    ks_rnd;
    logic [KW-1:0] ks_key;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] keyschedule_round(input logic [3:0] rnd,
                                                       input logic [127:0] oldkey);
        logic [31:0] rot;
        logic [31:0] tmp;
        logic [31:0] w0, w1, w2, w3;
        rot = {oldkey[23:0], oldkey[31:24]};
        tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(rnd), 24'h0};
        w0  = oldkey[127:96] ^ tmp;
        w1  = oldkey[95:64] ^ w0;
        w2  = oldkey[63:32] ^ w1;
        w3  = oldkey[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        key_accept = 1'b0;
        rk_fire    = 1'b0;
        last_rnd   = (rk_round_q == LAST_RND);
        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    key_accept = 1'b1;
                    state_nxt  = EXPAND;
                end
            end
            EXPAND: begin
                // abort wins over a coincident handshake
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.rk_ready) begin
                    rk_fire = 1'b1;
                    if (last_rnd) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Round input pinned at 1 whenever the function output is not consumed
    assign ks_rnd = (state == EXPAND && !last_rnd) ? rk_round_q + 4'd1 : 4'd1;
    assign ks_key = keyschedule_round(ks_rnd, rk_data_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_data_q   <= '0;
            rk_round_q  <= '0;
            tbl_valid_q <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                tbl[i] <= '0;
            end
        end else if (key_accept) begin
            rk_data_q   <= bus.key_in;
            rk_round_q  <= '0;
            tbl_valid_q <= 1'b0;
        end else if (rk_fire) begin
            tbl[rk_round_q] <= rk_data_q;
            if (last_rnd) begin
                tbl_valid_q <= 1'b1;
            end else begin
                rk_data_q  <= ks_key;
                rk_round_q <= rk_round_q + 4'd1;
            end
        end
    end

    assign bus.key_ready = (state == IDLE);
    assign bus.rk_valid  = (state == EXPAND);
    assign bus.rk_data   = rk_data_q;
    assign bus.rk_round  = rk_round_q;
    assign bus.done      = (state == DONE);
    assign bus.tbl_valid = tbl_valid_q;
    assign bus.rd_data   = (bus.rd_addr <= LAST_RND) ? tbl[bus.rd_addr] : '0;

endmodule

// File: tb/tb_aes128_keyexp_ctrl.sv
// Randomized bench for aes128_keyexp_ctrl against a key-schedule model whose S-box
// is derived from GF(2^8) inversion plus the affine map, with FIPS-197 vectors as anchors.
module tb_aes128_keyexp_ctrl;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [127:0] exp_rk [11];
    logic [127:0] a1_rk  [11];

    aes128_keyexp_ctrl_if bus ();

    aes128_keyexp_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Word-by-word FIPS-197 KeyExpansion into exp_rk
    task automatic ref_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t  = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present a key in IDLE; returns at the negedge after acceptance
    task automatic offer_key(input logic [127:0] key);
        @(negedge clk);
        check_eq("key_ready_idle", bus.key_ready, 1);
        bus.key_valid = 1'b1;
        bus.key_in    = key;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic run_key(input logic [127:0] key, input bit stall, input bit inject);
        int idx = 0;
        int last_hs = -1;
        int cyc = 0;
        int stall_cnt = 0;
        ref_expand(key);
        offer_key(key);
        while (idx < 11 && cyc < 400) begin
            check_eq("rk_valid", bus.rk_valid, 1);
            check_eq($sformatf("rk_data[%0d]", idx), bus.rk_data, exp_rk[idx]);
            check_eq("rk_round", bus.rk_round, 128'(idx));
            check_eq("done_low", bus.done, 0);
            check_eq("tbl_valid_low", bus.tbl_valid, 0);
            if (last_hs >= 0)
                check_eq($sformatf("tbl_live[%0d]", last_hs), bus.rd_data, exp_rk[last_hs]);
            bus.key_valid = inject && idx == 5;
            bus.key_in    = ~key;
            if (!stall) begin
                bus.rk_ready = 1'b1;
            end else if (stall_cnt > 0) begin
                bus.rk_ready = 1'b0;
                stall_cnt--;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.rk_ready = 1'b0;
                stall_cnt = 2;
            end else begin
                bus.rk_ready = 1'b1;
            end
            if (bus.rk_ready) begin
                last_hs     = idx;
                bus.rd_addr = 4'(idx);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.key_valid = 1'b0;
        check_eq("handshake_budget", 128'(cyc < 400), 1);
        check_eq("done_pulse", bus.done, 1);
        check_eq("rk_valid_after", bus.rk_valid, 0);
        check_eq("tbl_valid_set", bus.tbl_valid, 1);
        check_eq("key_ready_in_done", bus.key_ready, 0);
        check_eq("tbl_last", bus.rd_data, exp_rk[10]);
        @(negedge clk);
        check_eq("done_one_cycle", bus.done, 0);
        check_eq("key_ready_back", bus.key_ready, 1);
    endtask

    task automatic wait_round(input logic [3:0] r);
        int cyc = 0;
        while (!(bus.rk_valid && bus.rk_round == r) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_round", 128'(cyc < 50), 1);
    endtask

    initial begin
        logic [127:0] k;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.abort     = 1'b0;
        bus.rk_ready  = 1'b0;
        bus.rd_addr   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_key_ready", bus.key_ready, 1);
        check_eq("rst_rk_valid", bus.rk_valid, 0);
        check_eq("rst_rk_data", bus.rk_data, 0);
        check_eq("rst_rk_round", bus.rk_round, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_tbl_valid", bus.tbl_valid, 0);
        rst_n = 1'b1;

        // FIPS-197 A.1, no backpressure, plus reverse readback
        run_key(KEY_A1, 1'b0, 1'b0);
        for (int a = 10; a >= 0; a--) begin
            bus.rd_addr = 4'(a);
            #1;
            check_eq($sformatf("rdback[%0d]", a), bus.rd_data, exp_rk[a]);
        end
        bus.rd_addr = 4'd1;
        #1 check_eq("a1_round1", bus.rd_data, A1_R1);
        bus.rd_addr = 4'd10;
        #1 check_eq("a1_round10", bus.rd_data, A1_R10);
        for (int a = 11; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            #1 check_eq($sformatf("rd_oob[%0d]", a), bus.rd_data, 0);
        end
        check_eq("tbl_valid_idle", bus.tbl_valid, 1);

        // Same key with random 3-cycle stalls and an ignored key offered mid-stream
        run_key(KEY_A1, 1'b1, 1'b1);
        for (int r = 0; r < 11; r++) a1_rk[r] = exp_rk[r];

        // Abort at round 4 with a handshake offered on the same edge
        k = rand128();
        ref_expand(k);
        bus.rk_ready = 1'b1;
        offer_key(k);
        wait_round(4'd4);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("abort_rk_valid", bus.rk_valid, 0);
        check_eq("abort_tbl_valid", bus.tbl_valid, 0);
        check_eq("abort_done", bus.done, 0);
        check_eq("abort_key_ready", bus.key_ready, 1);
        bus.rd_addr = 4'd4;
        #1 check_eq("abort_no_write", bus.rd_data, a1_rk[4]);
        bus.rd_addr = 4'd3;
        #1 check_eq("abort_prior_write", bus.rd_data, exp_rk[3]);
        @(negedge clk);
        check_eq("abort_no_done", bus.done, 0);
        run_key(KEY_SEQ, 1'b0, 1'b0);
        bus.rd_addr = 4'd10;
        #1 check_eq("seq_round10", bus.rd_data, SEQ_R10);

        // Reset pulse at round 6
        k = rand128();
        bus.rk_ready = 1'b1;
        offer_key(k);
        wait_round(4'd6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_rst_rk_valid", bus.rk_valid, 0);
        check_eq("mid_rst_rk_data", bus.rk_data, 0);
        check_eq("mid_rst_rk_round", bus.rk_round, 0);
        check_eq("mid_rst_done", bus.done, 0);
        check_eq("mid_rst_tbl_valid", bus.tbl_valid, 0);
        check_eq("mid_rst_key_ready", bus.key_ready, 1);
        for (int a = 0; a < 11; a++) begin
            bus.rd_addr = 4'(a);
            #1 check_eq($sformatf("mid_rst_tbl[%0d]", a), bus.rd_data, 0);
        end
        run_key(rand128(), 1'b1, 1'b0);

        for (int n = 0; n < 3; n++) run_key(rand128(), n[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
